div_32bit_seq: RTL

Multicycle signed 32-bit divider for the processor's execute stage, paired with the AND-gated partial-product multiplier path. It accepts a dividend and divisor on a one-cycle start strobe. It computes quotient and remainder over 32 shift/subtract iterations on magnitudes, then applies sign correction. It reports completion with a one-cycle ready pulse and flags divide-by-zero and overflow.

---
 rtl/div_32bit_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div_32bit_seq.sv
// div_32bit_seq: multicycle signed 32-bit divider.
// Restoring shift/subtract on operand magnitudes (one quotient bit per
// cycle), followed by a sign-correction cycle. Divide-by-zero and the
// single overflow case (0x80000000 / -1) bypass the iterations and
// complete one cycle after the start is accepted.
//
// Handshake: ctrl_DIV is a start strobe that is only honoured while the FSM
// is IDLE (busy low). data_resultRDY is a one-cycle completion pulse. The
// result, remainder and exception outputs are valid while it is high and
// hold until the next completion or reset. There is no back-pressure. A
// start presented in the same cycle as the ready pulse is accepted because
// the FSM is already back in IDLE.
module div_32bit_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_EXC  = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  // Partial remainder. The shifted value is formed at 33 bits for the
  // subtract, but the kept remainder is always below |B| <= 2^31, so it is
  // stored in 32 bits.
  logic [31:0] r_rem;
  // Holds |A| at start and is shifted out into the remainder MSB-first while
  // the quotient bits shift in from the bottom.
  logic [31:0] r_q;
  logic [31:0] r_b_mag;
  logic [31:0] r_a_raw;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_dz;
  logic [31:0] r_result;
  logic [31:0] r_remainder;
  logic        r_exception;
  logic        r_rdy;
  logic        r_busy;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_dz;
  logic        w_ovf;
  logic [32:0] w_rem_shift;
  logic [32:0] w_diff;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Magnitudes wrap: |0x80000000| stays 0x80000000, read as unsigned.
  assign w_a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
  assign w_dz    = (data_operandB == 32'd0);
  assign w_ovf   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);

  // One restoring step: shift the next dividend bit in, trial-subtract |B|.
  assign w_rem_shift = {r_rem, r_q[31]};
  assign w_diff      = w_rem_shift - {1'b0, r_b_mag};

  // Sign correction: quotient negative when signs differ, remainder follows
  // the dividend.
  assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_q + 32'd1) : r_q;
  assign w_rem_fix = r_sign_a ? (~r_rem + 32'd1) : r_rem;

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_rem       <= 32'd0;
      r_q         <= 32'd0;
      r_b_mag     <= 32'd0;
      r_a_raw     <= 32'd0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_dz        <= 1'b0;
      r_result    <= 32'd0;
      r_remainder <= 32'd0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_DIV) begin
            r_sign_a <= data_operandA[31];
            r_sign_b <= data_operandB[31];
            r_q      <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_a_raw  <= data_operandA;
            r_dz     <= w_dz;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
            r_state  <= (w_dz || w_ovf) ? S_EXC : S_RUN;
          end
        end
        S_RUN: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_q   <= {r_q[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_shift[31:0];
            r_q   <= {r_q[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result    <= w_quo_fix;
          r_remainder <= w_rem_fix;
          r_exception <= 1'b0;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_EXC: begin
          if (r_dz) begin
            r_result    <= 32'd0;
            r_remainder <= r_a_raw;
          end else begin
            r_result    <= 32'h8000_0000;
            r_remainder <= 32'd0;
          end
          r_exception <= 1'b1;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule
